muldiv_seq: RTL and testbench

- Multi-cycle multiply/divide sequencer with architectural HI/LO registers for the MIPS single-cycle core.
- Replaces the combinational multiply/divide ops with an iterative radix-2 engine: shift-add for multiply, restoring algorithm for divide.
- Exposes a start/busy/done handshake. Core control stalls PC and register writeback while busy=1.
- Also services MTHI/MTLO writes. Core reads HI/LO continuously for MFHI/MFLO.

---
 rtl/muldiv_seq.sv | 211 +++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative multiply/divide sequencer holding the HI/LO registers.
//   Multiply is radix-2 shift-add and divide is restoring. Both run on operand
//   magnitudes, and the sign is fixed in a final cycle. MTHI/MTLO write HI/LO
//   directly in one edge.
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   i_start, i_op    request and opcode: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU,
//                    4 MTHI, 5 MTLO, 6-7 ignored
//   i_a, i_b         rs / rt operands
//   i_flush          abort the in-flight operation; drops a same-cycle start
//   o_busy           operation in progress
//   o_done           one-cycle pulse when a mul/div has written HI/LO
//   o_div_by_zero    pulses with o_done for a divide with b = 0
//   o_hi, o_lo       architectural HI/LO registers
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_flush,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_by_zero,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int CW = $clog2(WIDTH);

    // ST_DONE is the cycle in which o_done is visible. It still counts as busy.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [CW-1:0]    r_cnt;
    logic             r_is_div;
    logic             r_neg_lo;
    logic             r_neg_hi;
    logic             r_dbz;
    logic [WIDTH-1:0] r_mc;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0] r_ph;     // product high half or partial remainder
    logic [WIDTH-1:0] r_pl;     // product low half/multiplier, or quotient/dividend
    logic [WIDTH-1:0] r_raw_a;  // raw dividend, returned in HI on divide by zero
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;
    logic             r_dbz_out;

    // The final ST_DONE cycle can take a new request, so the next start is
    // sampled on the same edge on which busy drops.
    logic             w_can_start;
    logic             w_req;
    logic             w_accept;
    logic             w_mthi;
    logic             w_mtlo;
    logic             w_signed;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;

    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0] w_quot_fix;
    logic [WIDTH-1:0] w_rem_fix;
    logic             w_unused;

    assign w_can_start = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_req       = w_can_start && i_start && !i_flush;
    assign w_accept    = w_req && !i_op[2];
    assign w_mthi      = w_req && (i_op == 3'd4);
    assign w_mtlo      = w_req && (i_op == 3'd5);

    // Even opcodes (MULT, DIV) are signed. The negation of the most negative
    // value is read back as its unsigned magnitude.
    assign w_signed = !i_op[0];
    assign w_abs_a  = (w_signed && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_abs_b  = (w_signed && i_b[WIDTH-1]) ? -i_b : i_b;

    // Shift-add step: add the multiplicand when the multiplier LSB is set,
    // then shift the 65-bit {carry, high, low} right by one.
    assign w_add = r_pl[0] ? ({1'b0, r_ph} + {1'b0, r_mc}) : {1'b0, r_ph};

    // Restoring step: shift the next dividend bit into the remainder, then try
    // to subtract. The top bit of w_diff is the borrow.
    assign w_shift = {r_ph, r_pl[WIDTH-1]};
    assign w_diff  = {1'b0, w_shift} - {2'b00, r_mc};

    assign w_prod     = {r_ph, r_pl};
    assign w_prod_fix = r_neg_lo ? -w_prod : w_prod;
    assign w_quot_fix = r_neg_lo ? -r_pl : r_pl;
    assign w_rem_fix  = r_neg_hi ? -r_ph : r_ph;

    assign w_unused = &{1'b0, w_diff[WIDTH]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_next = ST_CALC;
            end
            ST_CALC: begin
                if (i_flush)                          w_next = ST_IDLE;
                else if (r_cnt == CW'(WIDTH - 1))     w_next = ST_FIX;
            end
            ST_FIX: begin
                if (i_flush) w_next = ST_IDLE;
                else         w_next = ST_DONE;
            end
            ST_DONE: begin
                if (w_accept) w_next = ST_CALC;
                else          w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_neg_lo  <= 1'b0;
            r_neg_hi  <= 1'b0;
            r_dbz     <= 1'b0;
            r_mc      <= '0;
            r_ph      <= '0;
            r_pl      <= '0;
            r_raw_a   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
            r_dbz_out <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_dbz_out <= 1'b0;

            if (w_accept) begin
                r_cnt    <= '0;
                r_is_div <= i_op[1];
                r_mc     <= w_abs_b;
                r_ph     <= '0;
                r_pl     <= w_abs_a;
                r_raw_a  <= i_a;
                r_dbz    <= i_op[1] && (i_b == '0);
                r_neg_lo <= w_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
                r_neg_hi <= w_signed && (i_op[1] ? i_a[WIDTH-1]
                                                 : (i_a[WIDTH-1] ^ i_b[WIDTH-1]));
            end

            if (r_state == ST_CALC && !i_flush) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_is_div) begin
                    if (!w_diff[WIDTH+1]) begin
                        r_ph <= w_diff[WIDTH-1:0];
                        r_pl <= {r_pl[WIDTH-2:0], 1'b1};
                    end else begin
                        r_ph <= w_shift[WIDTH-1:0];
                        r_pl <= {r_pl[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    r_ph <= w_add[WIDTH:1];
                    r_pl <= {w_add[0], r_pl[WIDTH-1:1]};
                end
            end

            if (r_state == ST_FIX && !i_flush) begin
                r_done    <= 1'b1;
                r_dbz_out <= r_dbz;
                if (!r_is_div) begin
                    r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                    r_lo <= w_prod_fix[WIDTH-1:0];
                end else if (r_dbz) begin
                    r_hi <= r_raw_a;
                    r_lo <= '1;
                end else begin
                    r_hi <= w_rem_fix;
                    r_lo <= w_quot_fix;
                end
            end

            if (w_mthi) r_hi <= i_a;
            if (w_mtlo) r_lo <= i_a;
        end
    end

    assign o_busy        = (r_state != ST_IDLE);
    assign o_done        = r_done;
    assign o_div_by_zero = r_dbz_out;
    assign o_hi          = r_hi;
    assign o_lo          = r_lo;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed self-checking bench for muldiv_seq.
module tb_muldiv_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic        dbz;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int failures;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (start),
        .i_op         (op),
        .i_a          (a),
        .i_b          (b),
        .i_flush      (flush),
        .o_busy       (busy),
        .o_done       (done),
        .o_div_by_zero(dbz),
        .o_hi         (hi),
        .o_lo         (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one mul/div, then wait (bounded) for done and for busy to drop.
    // lat is the negedge count after the sampling edge at which done was seen,
    // or -1 if it never arrived.
    task automatic run_op(input logic [2:0] o, input logic [31:0] va,
                          input logic [31:0] vb, output int lat,
                          output logic dbz_seen, output int busy_cycles,
                          output int done_pulses);
        lat = -1;
        dbz_seen = 1'b0;
        busy_cycles = 0;
        done_pulses = 0;
        @(negedge clk);
        start = 1'b1; op = o; a = va; b = vb;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (done) begin
                done_pulses++;
                if (lat < 0) begin
                    lat = k;
                    dbz_seen = dbz;
                end
            end
            if (lat >= 0 && !busy) break;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        start = 1'b0; op = 3'd0; a = '0; b = '0; flush = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (dbz !== 1'b0) begin failures++; $display("FAIL reset_dbz got=%b exp=0", dbz); end
        checks++; if (hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_multu_latency();
        int k_done = -1;
        int busy_n = 0;
        int pulses = 0;
        logic early_change = 1'b0;
        @(negedge clk);
        start = 1'b1; op = 3'd1; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        start = 1'b0; a = 32'h0; b = 32'h0;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                pulses++;
                if (k_done < 0) k_done = k;
            end
            if (k < 34 && (hi !== 32'h0 || lo !== 32'h0)) early_change = 1'b1;
            if (k == 34) begin
                checks++; if (hi !== 32'hFFFFFFFE) begin failures++; $display("FAIL multu_hi got=%h exp=fffffffe", hi); end
                checks++; if (lo !== 32'h00000001) begin failures++; $display("FAIL multu_lo got=%h exp=00000001", lo); end
                checks++; if (busy !== 1'b1) begin failures++; $display("FAIL multu_busy_at_done got=%b exp=1", busy); end
            end
        end
        checks++; if (k_done !== 34) begin failures++; $display("FAIL multu_latency got=%0d exp=34", k_done); end
        checks++; if (busy_n !== 34) begin failures++; $display("FAIL multu_busy_cycles got=%0d exp=34", busy_n); end
        checks++; if (pulses !== 1) begin failures++; $display("FAIL multu_done_pulses got=%0d exp=1", pulses); end
        checks++; if (early_change !== 1'b0) begin failures++; $display("FAIL multu_hilo_stable got=%b exp=0", early_change); end
    endtask

    task automatic test_signed();
        int lat, bc, dp;
        logic z;
        run_op(3'd0, 32'hFFFFFFF9, 32'd6, lat, z, bc, dp);
        checks++; if (lat !== 34) begin failures++; $display("FAIL mult_latency got=%0d exp=34", lat); end
        checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
        checks++; if (lo !== 32'hFFFFFFD6) begin failures++; $display("FAIL mult_lo got=%h exp=ffffffd6", lo); end
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, lat, z, bc, dp);
        checks++; if (lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_neg_quot got=%h exp=fffffffd", lo); end
        checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_neg_rem got=%h exp=ffffffff", hi); end
        run_op(3'd2, 32'd7, 32'hFFFFFFFE, lat, z, bc, dp);
        checks++; if (lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_posneg_quot got=%h exp=fffffffd", lo); end
        checks++; if (hi !== 32'h00000001) begin failures++; $display("FAIL div_posneg_rem got=%h exp=00000001", hi); end
    endtask

    task automatic test_div_special();
        int lat, bc, dp;
        logic z;
        run_op(3'd3, 32'd100, 32'd0, lat, z, bc, dp);
        checks++; if (lat !== 34) begin failures++; $display("FAIL dbz_latency got=%0d exp=34", lat); end
        checks++; if (z !== 1'b1) begin failures++; $display("FAIL dbz_flag got=%b exp=1", z); end
        checks++; if (lo !== 32'hFFFFFFFF) begin failures++; $display("FAIL dbz_lo got=%h exp=ffffffff", lo); end
        checks++; if (hi !== 32'd100) begin failures++; $display("FAIL dbz_hi got=%h exp=00000064", hi); end
        run_op(3'd2, 32'hFFFFFFF9, 32'd0, lat, z, bc, dp);
        checks++; if (z !== 1'b1) begin failures++; $display("FAIL dbz_signed_flag got=%b exp=1", z); end
        checks++; if (hi !== 32'hFFFFFFF9) begin failures++; $display("FAIL dbz_signed_hi got=%h exp=fffffff9", hi); end
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, lat, z, bc, dp);
        checks++; if (z !== 1'b0) begin failures++; $display("FAIL ovf_flag got=%b exp=0", z); end
        checks++; if (lo !== 32'h80000000) begin failures++; $display("FAIL ovf_lo got=%h exp=80000000", lo); end
        checks++; if (hi !== 32'h00000000) begin failures++; $display("FAIL ovf_hi got=%h exp=00000000", hi); end
    endtask

    task automatic test_mthi_mtlo();
        @(negedge clk);
        start = 1'b1; op = 3'd4; a = 32'h12345678;
        @(posedge clk);
        #1;
        checks++; if (hi !== 32'h12345678) begin failures++; $display("FAIL mthi_hi got=%h exp=12345678", hi); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mthi_busy got=%b exp=0", busy); end
        op = 3'd5; a = 32'h9ABCDEF0;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++; if (lo !== 32'h9ABCDEF0) begin failures++; $display("FAIL mtlo_lo got=%h exp=9abcdef0", lo); end
        checks++; if (hi !== 32'h12345678) begin failures++; $display("FAIL mtlo_hi_kept got=%h exp=12345678", hi); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL mtlo_busy_done got=%b%b exp=00", busy, done); end
        // Reserved opcode: nothing happens.
        @(negedge clk);
        start = 1'b1; op = 3'd6; a = 32'h55555555; b = 32'h1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reserved_busy got=%b exp=0", busy); end
        checks++; if (hi !== 32'h12345678 || lo !== 32'h9ABCDEF0) begin failures++; $display("FAIL reserved_hilo got=%h_%h exp=12345678_9abcdef0", hi, lo); end
    endtask

    task automatic test_flush();
        int lat, bc, dp;
        int late_done = 0;
        logic z;
        @(negedge clk);
        start = 1'b1; op = 3'd3; a = 32'd50; b = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        // A start while busy must not be queued.
        start = 1'b1; op = 3'd1; a = 32'd2; b = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", busy); end
        checks++; if (hi !== 32'h12345678 || lo !== 32'h9ABCDEF0) begin failures++; $display("FAIL flush_hilo got=%h_%h exp=12345678_9abcdef0", hi, lo); end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || busy) late_done++;
        end
        checks++; if (late_done !== 0) begin failures++; $display("FAIL flush_no_done got=%0d exp=0", late_done); end
        run_op(3'd3, 32'd50, 32'd7, lat, z, bc, dp);
        checks++; if (lo !== 32'd7) begin failures++; $display("FAIL divu_after_flush_lo got=%h exp=00000007", lo); end
        checks++; if (hi !== 32'd1) begin failures++; $display("FAIL divu_after_flush_hi got=%h exp=00000001", hi); end
        checks++; if (dp !== 1) begin failures++; $display("FAIL divu_after_flush_pulses got=%0d exp=1", dp); end
        // Flush during FIX beats the HI/LO write.
        @(negedge clk);
        start = 1'b1; op = 3'd3; a = 32'd9; b = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (33) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL flush_fix_done_busy got=%b%b exp=00", done, busy); end
        checks++; if (hi !== 32'd1 || lo !== 32'd7) begin failures++; $display("FAIL flush_fix_hilo got=%h_%h exp=00000001_00000007", hi, lo); end
        // Flush in IDLE drops a same-cycle MTHI.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 3'd4; a = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        checks++; if (hi !== 32'd1) begin failures++; $display("FAIL flush_idle_mthi got=%h exp=00000001", hi); end
    endtask

    task automatic test_async_reset();
        int lat, bc, dp;
        logic z;
        @(negedge clk);
        start = 1'b1; op = 3'd3; a = 32'd1000; b = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || dbz !== 1'b0) begin failures++; $display("FAIL areset_ctrl got=%b%b%b exp=000", busy, done, dbz); end
        checks++; if (hi !== 32'h0 || lo !== 32'h0) begin failures++; $display("FAIL areset_hilo got=%h_%h exp=00000000_00000000", hi, lo); end
        @(negedge clk);
        #2 rst_n = 1'b1;
        run_op(3'd1, 32'd3, 32'd5, lat, z, bc, dp);
        checks++; if (lat !== 34) begin failures++; $display("FAIL areset_mul_latency got=%0d exp=34", lat); end
        checks++; if (hi !== 32'h0 || lo !== 32'd15) begin failures++; $display("FAIL areset_mul_result got=%h_%h exp=00000000_0000000f", hi, lo); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_multu_latency();
        test_signed();
        test_div_special();
        test_mthi_mtlo();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
